button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Front-end for one push-button input: synchronises the raw pad signal and
//   debounces it on a slow sample strobe. Emits a clean level plus one-clk
//   press / release / long-press pulses.
//   Sits directly upstream of the alert-panel controller; one instance per
//   button (b1, b2).
// PARAMETERS
//   SYNC_STAGES     2   synchroniser depth on pb, >=2
//   DEBOUNCE_TICKS  4   consecutive equal-valued sample ticks needed to accept an edge, >=1
//   LONG_TICKS      50  sample ticks held (after press accepted) before long_press, >=1
// PORTS
//   clk         in   1  single system clock; all flops on posedge clk
//   rst         in   1  asynchronous, active-high reset
//   tick_en     in   1  sample strobe from clock divider, 1 clk wide; gates all counting
//   pb          in   1  raw, asynchronous, bouncing button input (1 = pressed)
//   level       out  1  debounced button state
//   press       out  1  one-clk pulse when a press is accepted
//   release_p   out  1  one-clk pulse when a release is accepted
//   long_press  out  1  one-clk pulse, at most once per press, after LONG_TICKS held
// BEHAVIOUR
//   Reset (async, while rst=1):
//   - state=IDLE; sync flops, cnt, hcnt and long_done cleared.
//   - All outputs 0.
//   - Reset mid-press forces level=0 immediately and emits no release_p.
//   - After reset, a still-held pb is debounced afresh and reported as a new press.
//   Synchroniser: pb passes through SYNC_STAGES flops every clk (ungated); output is pb_s.
//   Sampling: pb_s is evaluated only on clk edges where tick_en=1. pb_s changes
//   between ticks are invisible.
//   States (enum in package):
//   - IDLE: level=0. Tick with pb_s=1 -> PRESS_WAIT, cnt=1.
//     If DEBOUNCE_TICKS=1, go straight to HELD with press.
//   - PRESS_WAIT: tick with pb_s=1 -> cnt++.
//     When cnt reaches DEBOUNCE_TICKS: -> HELD, level<=1, press<=1, hcnt=0.
//     Tick with pb_s=0 -> IDLE, cnt=0.
//   - HELD: level=1.
//     Tick with pb_s=1 -> hcnt++ (saturates at LONG_TICKS).
//     When hcnt reaches LONG_TICKS and long_done=0: long_press<=1, long_done<=1.
//     Tick with pb_s=0 -> RELEASE_WAIT, cnt=1 (hcnt frozen).
//   - RELEASE_WAIT: level stays 1.
//     Tick with pb_s=0 -> cnt++; at DEBOUNCE_TICKS -> IDLE, level<=0,
//     release_p<=1, long_done<=0.
//     Tick with pb_s=1 -> HELD, cnt=0, no press pulse (bounce absorbed).
//   Outputs:
//   - All outputs are registered.
//   - Each pulse is high exactly one clk cycle, in the cycle after the qualifying edge.
//   - press and release_p are never high together.
//   - long_press never coincides with press, even if LONG_TICKS=1 (it fires
//     at the earliest on the next tick).
//   Latency (tick_en=1, edges numbered from the first edge after pb rises):
//   - press/level rise after edge SYNC_STAGES+DEBOUNCE_TICKS.
//   - Release latency is symmetric.
//   Widths:
//   - cnt is $clog2(DEBOUNCE_TICKS+1) bits.
//   - hcnt is $clog2(LONG_TICKS+1) bits.
//   - Counters never wrap.
// STRUCTURE
//   - Package btn_pkg: typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD,
//     RELEASE_WAIT} btn_state_t.
//   - Sub-module sync_ff #(STAGES): plain async-reset flop chain, reused for
//     any other async input.
//   - FSM and both counters live in this module; elaboration-time asserts
//     check the parameter minimums.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_TICKS=4, LONG_TICKS=8, tick_en=1 unless noted)
//   1. rst=1 with pb=1 -> all outputs 0; drop rst -> press pulses after edge 6, level=1.
//   2. pb high 3 clks then low -> press, level and release_p stay 0 throughout.
//   3. pb high 20 clks -> press after edge 6; long_press single pulse after
//      edge 14; no second long_press.
//   4. While held, pb low 2 clks, high 1 clk, high steady -> level stays 1,
//      no release_p, no extra press.
//   5. tick_en every 4th clk, pb steady high -> press after the 4th
//      qualifying tick (~16 clks + sync).
//   6. Assert rst while level=1 -> level falls asynchronously, release_p
//      never pulses.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Purpose : shared types and helpers for the push-button conditioner.
// Latency : n/a (types only).
// Backpressure: n/a.
package btn_pkg;

    // Debounce FSM states. PRESS_WAIT/RELEASE_WAIT are the counting states
    // where an edge is being qualified but not yet accepted.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_sync.sv
// Purpose : plain async-reset flop chain bringing an asynchronous input into clk.
// Latency : STAGES clk cycles, ungated.
// Backpressure: none.
// Ports   : clk, rst (async active-high), d_i (async input), q_o (synchronised).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Purpose : synchronise + debounce one push-button; clean level and press/release/long-press pulses.
// Latency : press/level after SYNC_STAGES+DEBOUNCE_TICKS ticks; release symmetric.
// Backpressure: none; pulses are single-cycle and fire-and-forget.
// Ports   : clk, rst (async active-high), tick_en (sample strobe), pb (raw pad),
//           level (debounced state), press / release_p / long_press (1-clk pulses).
module button_conditioner
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int LONG_TICKS     = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    input  logic pb,
    output logic level,
    output logic press,
    output logic release_p,
    output logic long_press
);

    localparam int CW = cnt_width(DEBOUNCE_TICKS);
    localparam int HW = cnt_width(LONG_TICKS);

    // Counting states compare against the value *before* the final increment,
    // so the accepting tick is the DEBOUNCE_TICKS-th consecutive equal sample.
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_TICKS);
    localparam bit            DEB_ONE   = (DEBOUNCE_TICKS == 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("button_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_TICKS < 1) begin : g_chk_deb
        $error("button_conditioner: DEBOUNCE_TICKS must be >= 1");
    end
    if (LONG_TICKS < 1) begin : g_chk_long
        $error("button_conditioner: LONG_TICKS must be >= 1");
    end

    logic       pb_s;
    btn_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic [HW-1:0] hcnt_q;
    logic       long_done_q;
    logic       level_q;
    logic       press_q;
    logic       release_q;
    logic       long_press_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pb),
        .q_o (pb_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            long_done_q  <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            // Pulses default low so each is exactly one clk wide.
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;

            if (tick_en) begin
                case (state_q)
                    IDLE: begin
                        if (pb_s) begin
                            if (DEB_ONE) begin
                                state_q <= HELD;
                                level_q <= 1'b1;
                                press_q <= 1'b1;
                                hcnt_q  <= '0;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= PRESS_WAIT;
                                cnt_q   <= CW'(1);
                            end
                        end
                    end

                    PRESS_WAIT: begin
                        if (pb_s) begin
                            if (cnt_q == DEB_LAST) begin
                                state_q <= HELD;
                                level_q <= 1'b1;
                                press_q <= 1'b1;
                                hcnt_q  <= '0;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end

                    HELD: begin
                        if (pb_s) begin
                            if (hcnt_q != LONG_MAX) begin
                                hcnt_q <= hcnt_q + 1'b1;
                            end
                            // Fires on the tick that takes hcnt to LONG_TICKS; hcnt
                            // starts at 0 on press, so this is never the press cycle.
                            if (hcnt_q == LONG_LAST && !long_done_q) begin
                                long_press_q <= 1'b1;
                                long_done_q  <= 1'b1;
                            end
                        end else if (DEB_ONE) begin
                            state_q     <= IDLE;
                            level_q     <= 1'b0;
                            release_q   <= 1'b1;
                            long_done_q <= 1'b0;
                        end else begin
                            // hcnt is left frozen so a bounce does not restart long-press timing.
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= CW'(1);
                        end
                    end

                    RELEASE_WAIT: begin
                        if (!pb_s) begin
                            if (cnt_q == DEB_LAST) begin
                                state_q     <= IDLE;
                                level_q     <= 1'b0;
                                release_q   <= 1'b1;
                                long_done_q <= 1'b0;
                                cnt_q       <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else begin
                            // Bounce absorbed: back to HELD without a new press.
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign level      = level_q;
    assign press      = press_q;
    assign release_p  = release_q;
    assign long_press = long_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic tick_en;
    logic pb;
    logic level;
    logic press;
    logic release_p;
    logic long_press;

    int total = 0;
    int bad   = 0;

    button_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_TICKS (4),
        .LONG_TICKS     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_en    (tick_en),
        .pb         (pb),
        .level      (level),
        .press      (press),
        .release_p  (release_p),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pb = 1'b1; tick_en = 1'b1;
        repeat (3) step();
        total++; if (level !== 1'b0)      begin bad++; $display("FAIL rst_level got=%b exp=0", level); end
        total++; if (press !== 1'b0)      begin bad++; $display("FAIL rst_press got=%b exp=0", press); end
        total++; if (release_p !== 1'b0)  begin bad++; $display("FAIL rst_release got=%b exp=0", release_p); end
        total++; if (long_press !== 1'b0) begin bad++; $display("FAIL rst_long got=%b exp=0", long_press); end
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            total++; if (press !== (e == 6)) begin bad++; $display("FAIL t1_press e=%0d got=%b exp=%b", e, press, (e == 6)); end
            total++; if (level !== (e >= 6)) begin bad++; $display("FAIL t1_level e=%0d got=%b exp=%b", e, level, (e >= 6)); end
            total++; if (release_p !== 1'b0) begin bad++; $display("FAIL t1_release e=%0d got=%b exp=0", e, release_p); end
        end
        pb = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            total++; if (release_p !== (e == 6)) begin bad++; $display("FAIL t1_rel e=%0d got=%b exp=%b", e, release_p, (e == 6)); end
            total++; if (level !== (e < 6)) begin bad++; $display("FAIL t1_rlevel e=%0d got=%b exp=%b", e, level, (e < 6)); end
            total++; if (press !== 1'b0) begin bad++; $display("FAIL t1_rpress e=%0d got=%b exp=0", e, press); end
        end
    endtask

    task automatic test_short_glitch();
        pb = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (e == 3) pb = 1'b0;
            total++; if (press !== 1'b0)     begin bad++; $display("FAIL t2_press e=%0d got=%b exp=0", e, press); end
            total++; if (level !== 1'b0)     begin bad++; $display("FAIL t2_level e=%0d got=%b exp=0", e, level); end
            total++; if (release_p !== 1'b0) begin bad++; $display("FAIL t2_release e=%0d got=%b exp=0", e, release_p); end
        end
    endtask

    task automatic test_long_press();
        pb = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 20) pb = 1'b0;
            total++; if (press !== (e == 6))       begin bad++; $display("FAIL t3_press e=%0d got=%b exp=%b", e, press, (e == 6)); end
            total++; if (long_press !== (e == 14)) begin bad++; $display("FAIL t3_long e=%0d got=%b exp=%b", e, long_press, (e == 14)); end
            total++; if (release_p !== (e == 26))  begin bad++; $display("FAIL t3_release e=%0d got=%b exp=%b", e, release_p, (e == 26)); end
            total++; if (level !== (e >= 6 && e < 26)) begin bad++; $display("FAIL t3_level e=%0d got=%b exp=%b", e, level, (e >= 6 && e < 26)); end
        end
    endtask

    task automatic test_bounce_while_held();
        int n_rel;
        pb = 1'b1;
        repeat (8) step();
        total++; if (level !== 1'b1) begin bad++; $display("FAIL t4_held got=%b exp=1", level); end
        // Low for 2 clks, high for 1, then high steady.
        pb = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (e == 2) pb = 1'b1;
            total++; if (level !== 1'b1)     begin bad++; $display("FAIL t4_level e=%0d got=%b exp=1", e, level); end
            total++; if (release_p !== 1'b0) begin bad++; $display("FAIL t4_release e=%0d got=%b exp=0", e, release_p); end
            total++; if (press !== 1'b0)     begin bad++; $display("FAIL t4_press e=%0d got=%b exp=0", e, press); end
        end
        pb = 1'b0;
        n_rel = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (release_p === 1'b1) n_rel++;
        end
        total++; if (n_rel != 1)     begin bad++; $display("FAIL t4_release_count got=%0d exp=1", n_rel); end
        total++; if (level !== 1'b0) begin bad++; $display("FAIL t4_final_level got=%b exp=0", level); end
    endtask

    task automatic test_slow_tick();
        pb = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick_en = (e % 4 == 0);
            step();
            total++; if (press !== (e == 16)) begin bad++; $display("FAIL t5_press e=%0d got=%b exp=%b", e, press, (e == 16)); end
            total++; if (level !== (e >= 16)) begin bad++; $display("FAIL t5_level e=%0d got=%b exp=%b", e, level, (e >= 16)); end
        end
        tick_en = 1'b1;
        pb = 1'b0;
        repeat (10) step();
        total++; if (level !== 1'b0) begin bad++; $display("FAIL t5_final_level got=%b exp=0", level); end
    endtask

    task automatic test_reset_while_held();
        pb = 1'b1;
        repeat (10) step();
        total++; if (level !== 1'b1) begin bad++; $display("FAIL t6_held got=%b exp=1", level); end
        // Assert reset mid-cycle, well away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        total++; if (level !== 1'b0) begin bad++; $display("FAIL t6_async_level got=%b exp=0", level); end
        repeat (2) begin
            step();
            total++; if (release_p !== 1'b0) begin bad++; $display("FAIL t6_rst_release got=%b exp=0", release_p); end
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            total++; if (press !== (e == 6))  begin bad++; $display("FAIL t6_repress e=%0d got=%b exp=%b", e, press, (e == 6)); end
            total++; if (level !== (e >= 6))  begin bad++; $display("FAIL t6_level e=%0d got=%b exp=%b", e, level, (e >= 6)); end
            total++; if (release_p !== 1'b0)  begin bad++; $display("FAIL t6_release e=%0d got=%b exp=0", e, release_p); end
        end
        pb = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        rst = 1'b1;
        pb = 1'b0;
        tick_en = 1'b1;
        test_reset();
        test_short_glitch();
        test_long_press();
        test_bounce_while_held();
        test_slow_tick();
        test_reset_while_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
